dac_output_formatter: RTL

Parametrised multi-channel DAC output stage. It sits between the DUC sample path and the DAC pins. For each channel it rounds or truncates a wide two's-complement sample down to DAC width and saturates it. It then applies a shared click-free mute/unmute gain ramp and converts the result to the selected DAC code format, either offset binary (MSB inverted) or two's complement. All channels share one valid strobe and one fixed-latency registered pipeline.

---
 rtl/dac_fmt_pkg.sv | 20 ++
 rtl/dac_gain_ramp.sv | 76 +++++++
 rtl/dac_output_formatter.sv | 115 +++++++++++
 3 files changed

// File: rtl/dac_fmt_pkg.sv
// Shared types and constants for the DAC output formatter.
// Holds the ramp FSM states, output code format selectors and a midscale helper.
package dac_fmt_pkg;

    typedef enum logic [1:0] {
        MUTED     = 2'd0,
        RAMP_UP   = 2'd1,
        ACTIVE    = 2'd2,
        RAMP_DOWN = 2'd3
    } ramp_state_t;

    localparam logic FMT_OFFSET_BIN = 1'b0;
    localparam logic FMT_TWOS       = 1'b1;

    // Offset-binary code for a zero sample of the given width.
    function automatic logic [31:0] midscale_code(input int width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/dac_gain_ramp.sv
// Shared mute/unmute gain ramp: steps the gain by one every clock toward the
// level requested by mute, and reverses mid-ramp without jumping.
//
//   state     | meaning
//   ----------+-------------------------------------------
//   MUTED     | gain held at 0
//   RAMP_UP   | gain increments each clock toward G_MAX
//   ACTIVE    | gain held at G_MAX (unity)
//   RAMP_DOWN | gain decrements each clock toward 0
module dac_gain_ramp
    import dac_fmt_pkg::*;
#(
    parameter int RAMP_LOG2 = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mute,
    output logic [RAMP_LOG2:0] gain,
    output logic               muted,
    output logic               ramp_busy
);

    localparam logic [RAMP_LOG2:0] G_MAX = {1'b1, {RAMP_LOG2{1'b0}}};

    ramp_state_t        state_q, state_d;
    logic [RAMP_LOG2:0] gain_q, gain_d;
    logic [RAMP_LOG2:0] gain_up, gain_dn;

    assign gain_up = gain_q + 1'b1;
    assign gain_dn = gain_q - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MUTED;
            gain_q  <= '0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
        end
    end

    // The step always lands first; reaching an endpoint beats a reversal request.
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        case (state_q)
            MUTED: begin
                gain_d = '0;
                if (!mute) state_d = RAMP_UP;
            end
            RAMP_UP: begin
                gain_d = gain_up;
                if (gain_up == G_MAX) state_d = ACTIVE;
                else if (mute)        state_d = RAMP_DOWN;
            end
            ACTIVE: begin
                gain_d = G_MAX;
                if (mute) state_d = RAMP_DOWN;
            end
            RAMP_DOWN: begin
                gain_d = gain_dn;
                if (gain_dn == '0) state_d = MUTED;
                else if (!mute)    state_d = RAMP_UP;
            end
            default: begin
                state_d = MUTED;
                gain_d  = '0;
            end
        endcase
    end

    assign gain      = gain_q;
    assign muted     = (state_q == MUTED);
    assign ramp_busy = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);

endmodule

// File: rtl/dac_output_formatter.sv
// Multi-channel DAC output stage: quantise+saturate, shared gain ramp, code format.
// Define DAC_FMT_ROUND_EN to round half-up before the quantising shift (default: floor).
module dac_output_formatter
    import dac_fmt_pkg::*;
#(
    parameter int IN_W      = 16,
    parameter int DAC_W     = 14,
    parameter int NCH       = 2,
    parameter int RAMP_LOG2 = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [NCH*IN_W-1:0]  in_data,
    input  logic                 fmt_sel,
    input  logic                 mute,
    output logic                 out_valid,
    output logic [NCH*DAC_W-1:0] out_data,
    output logic [NCH-1:0]       sat_flag,
    output logic                 ramp_busy,
    output logic                 muted
);

    localparam int SHIFT = IN_W - DAC_W;
    localparam int PW    = DAC_W + RAMP_LOG2 + 2;
    localparam logic [DAC_W-1:0]     MID   = DAC_W'(midscale_code(DAC_W));
    localparam logic signed [IN_W:0] Q_MAX = (IN_W+1)'((1 << (DAC_W-1)) - 1);
    localparam logic signed [IN_W:0] Q_MIN = ~Q_MAX;
`ifdef DAC_FMT_ROUND_EN
    localparam logic signed [IN_W:0] RND   = (IN_W+1)'(1 << (SHIFT-1));
`endif

    logic [RAMP_LOG2:0] gain;
    logic               v1, v2;

    dac_gain_ramp #(.RAMP_LOG2(RAMP_LOG2)) u_ramp (
        .clk       (clk),
        .rst       (rst),
        .mute      (mute),
        .gain      (gain),
        .muted     (muted),
        .ramp_busy (ramp_busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            v1        <= in_valid;
            v2        <= v1;
            out_valid <= v2;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic signed [IN_W:0]    ext, shifted;
        logic signed [DAC_W-1:0] q_c, y_c, s1_q, s2_y;
        logic                    sat_c, s1_sat, s2_sat, sat_q;
        logic [DAC_W-1:0]        code_q;

        // One spare bit keeps the rounding add from wrapping at +full-scale.
        assign ext = {in_data[k*IN_W+IN_W-1], in_data[k*IN_W +: IN_W]};
`ifdef DAC_FMT_ROUND_EN
        assign shifted = (ext + RND) >>> SHIFT;
`else
        assign shifted = ext >>> SHIFT;
`endif

        always_comb begin
            q_c   = shifted[DAC_W-1:0];
            sat_c = 1'b0;
            if (shifted > Q_MAX) begin
                q_c   = Q_MAX[DAC_W-1:0];
                sat_c = 1'b1;
            end else if (shifted < Q_MIN) begin
                q_c   = Q_MIN[DAC_W-1:0];
                sat_c = 1'b1;
            end
        end

        // Floor of x*g/G_MAX; cannot overflow DAC_W because g never exceeds G_MAX.
        assign y_c = DAC_W'((PW'(s1_q) * PW'($signed({1'b0, gain}))) >>> RAMP_LOG2);

        always_ff @(posedge clk) begin
            if (rst) begin
                s1_q   <= '0;
                s1_sat <= 1'b0;
                s2_y   <= '0;
                s2_sat <= 1'b0;
                code_q <= MID;
                sat_q  <= 1'b0;
            end else begin
                if (in_valid) begin
                    s1_q   <= q_c;
                    s1_sat <= sat_c;
                end
                if (v1) begin
                    s2_y   <= y_c;
                    s2_sat <= s1_sat;
                end
                if (v2) begin
                    code_q <= (fmt_sel == FMT_TWOS) ? s2_y
                                                    : {~s2_y[DAC_W-1], s2_y[DAC_W-2:0]};
                    sat_q  <= s2_sat;
                end
            end
        end

        assign out_data[k*DAC_W +: DAC_W] = code_q;
        assign sat_flag[k]                = sat_q;
    end

endmodule
